// File: rtl/miriscv_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter slice.
package miriscv_mem_pkg;

  localparam int MAX_PORTS = 4;
  localparam int MAX_PID_W = $clog2(MAX_PORTS);

  // One requester's access, as presented to the memory.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // One stage of the in-flight response tracker.
  typedef struct packed {
    logic                 valid;
    logic [MAX_PID_W-1:0] pid;
    logic                 we;
  } rsp_slot_t;

endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// slave: the arbiter's view; master: the requesters/memory environment.
interface miriscv_mem_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]       p_req_i;
  logic [NUM_PORTS-1:0]       p_we_i;
  logic [NUM_PORTS-1:0][3:0]  p_be_i;
  logic [NUM_PORTS-1:0][31:0] p_addr_i;
  logic [NUM_PORTS-1:0][31:0] p_wdata_i;
  logic [NUM_PORTS-1:0]       p_gnt_o;
  logic [NUM_PORTS-1:0]       p_rvalid_o;
  logic [31:0]                p_rdata_o;

  logic                       mem_ready_i;
  logic                       mem_req_o;
  logic                       mem_we_o;
  logic [3:0]                 mem_be_o;
  logic [31:0]                mem_addr_o;
  logic [31:0]                mem_wdata_o;
  logic [31:0]                mem_rdata_i;

  modport slave (
    input  p_req_i, p_we_i, p_be_i, p_addr_i, p_wdata_i, mem_ready_i, mem_rdata_i,
    output p_gnt_o, p_rvalid_o, p_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output p_req_i, p_we_i, p_be_i, p_addr_i, p_wdata_i, mem_ready_i, mem_rdata_i,
    input  p_gnt_o, p_rvalid_o, p_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/miriscv_mem_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester found
// searching upward from last_grant+1, wrapping past N-1 to 0.
module miriscv_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 enable,
  output logic [N-1:0]         gnt
);

  localparam int W = $clog2(N);

  logic [W-1:0] w_idx;
  logic         w_found;

  // Rotating priority search, first hit wins.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_idx = W'((32'(last_grant) + off) % 32'(N));
      if (enable && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares the data-memory port between NUM_PORTS requesters with
// same-cycle round-robin grants and routes each response back to its issuer.
module miriscv_mem_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  miriscv_mem_arbiter_if.slave bus
);

  localparam int PID_W = $clog2(NUM_PORTS);

  logic [PID_W-1:0]     r_last_grant;
  rsp_slot_t            r_pipe [RD_LATENCY];

  logic [NUM_PORTS-1:0] w_gnt;
  logic                 w_enable;
  logic                 w_accept;
  logic [PID_W-1:0]     w_pid;
  mem_req_t             w_sel;
  rsp_slot_t            w_exit;

  // No grants while reset is held, so the memory sees an idle bus.
  assign w_enable = bus.mem_ready_i & ~arstn_i;

  miriscv_rr_arbiter #(
    .N (NUM_PORTS)
  ) u_rr (
    .req        (bus.p_req_i),
    .last_grant (r_last_grant),
    .enable     (w_enable),
    .gnt        (w_gnt)
  );

  assign w_accept = |(bus.p_req_i & w_gnt);
  assign w_exit   = r_pipe[RD_LATENCY-1];

  // Select the granted port's access and its id; all-zero when idle.
  always_comb begin
    w_pid = '0;
    w_sel = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (w_gnt[k]) begin
        w_pid       = PID_W'(k);
        w_sel.we    = bus.p_we_i[k];
        w_sel.be    = bus.p_be_i[k];
        w_sel.addr  = bus.p_addr_i[k];
        w_sel.wdata = bus.p_wdata_i[k];
      end
    end
  end

  // Drive the memory request and the grant vector.
  always_comb begin
    bus.p_gnt_o     = w_gnt;
    bus.mem_req_o   = w_accept;
    bus.mem_we_o    = w_sel.we;
    bus.mem_be_o    = w_sel.be;
    bus.mem_addr_o  = w_sel.addr & 32'hFFFF_FFFC;
    bus.mem_wdata_o = w_sel.wdata;
  end

  // Remember the last port served; reset points at the top port so port 0 goes first.
  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      r_last_grant <= PID_W'(NUM_PORTS - 1);
    end else if (w_accept) begin
      r_last_grant <= w_pid;
    end
  end

  // Track in-flight accesses; reset drops them so no stale rvalid escapes.
  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_accept;
      r_pipe[0].pid   <= MAX_PID_W'(w_pid);
      r_pipe[0].we    <= w_sel.we;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Route the exiting response to its issuer; writes return zero data as an ack.
  always_comb begin
    bus.p_rvalid_o = '0;
    bus.p_rdata_o  = '0;
    if (w_exit.valid) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (w_exit.pid == MAX_PID_W'(k)) begin
          bus.p_rvalid_o[k] = 1'b1;
        end
      end
      if (!w_exit.we) begin
        bus.p_rdata_o = bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench: one random requester stream drives two arbiters (latency 1 and 3);
// a reference grant model feeds per-DUT response scoreboards.
module tb_miriscv_mem_arbiter;

  localparam int NP   = 2;
  localparam int NCYC = 320;

  typedef struct {
    int   port;
    logic we;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic arstn = 1'b1;

  logic [NP-1:0]       t_req = '0;
  logic [NP-1:0]       t_we = '0;
  logic [NP-1:0][3:0]  t_be = '0;
  logic [NP-1:0][31:0] t_addr = '0;
  logic [NP-1:0][31:0] t_wdata = '0;
  logic                t_ready = 1'b1;
  logic [31:0]         t_rdata = '0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q [2][$];

  always #5 clk = ~clk;

  miriscv_mem_arbiter_if #(.NUM_PORTS(NP)) ifa ();
  miriscv_mem_arbiter_if #(.NUM_PORTS(NP)) ifb ();

  assign ifa.p_req_i = t_req;     assign ifb.p_req_i = t_req;
  assign ifa.p_we_i = t_we;       assign ifb.p_we_i = t_we;
  assign ifa.p_be_i = t_be;       assign ifb.p_be_i = t_be;
  assign ifa.p_addr_i = t_addr;   assign ifb.p_addr_i = t_addr;
  assign ifa.p_wdata_i = t_wdata; assign ifb.p_wdata_i = t_wdata;
  assign ifa.mem_ready_i = t_ready; assign ifb.mem_ready_i = t_ready;
  assign ifa.mem_rdata_i = t_rdata; assign ifb.mem_rdata_i = t_rdata;

  miriscv_mem_arbiter #(.NUM_PORTS(NP), .RD_LATENCY(1)) dut_l1 (
    .clk_i (clk), .arstn_i (arstn), .bus (ifa)
  );
  miriscv_mem_arbiter #(.NUM_PORTS(NP), .RD_LATENCY(3)) dut_l3 (
    .clk_i (clk), .arstn_i (arstn), .bus (ifb)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Round-robin rule: first requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int off = 1; off <= NP; off++) begin
      if (req[(last + off) % NP]) return (last + off) % NP;
    end
    return -1;
  endfunction

  // Driver plus grant model
  initial begin
    logic [NP-1:0] pend;
    int            ptr;
    int            eg;
    logic          rst;
    logic [NP-1:0] eg_oh;
    logic [31:0]   e_addr;
    pend = '0;
    ptr  = NP - 1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      cyc = c;
      rst = (c < 2) || (c == 100) || (c == 200);
      arstn = rst;
      if (rst) begin
        q[0].delete();
        q[1].delete();
        ptr = NP - 1;
      end
      if (c < 8) t_ready = 1'b1;
      else if (c < 11) t_ready = 1'b0;
      else t_ready = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < NP; k++) begin
        if (!pend[k] && ((c < 14) || ($urandom_range(0, 9) < 6))) begin
          pend[k]    = 1'b1;
          t_we[k]    = 1'($urandom_range(0, 1));
          t_be[k]    = 4'($urandom);
          t_addr[k]  = $urandom;
          t_wdata[k] = $urandom;
          if (c == 0 && k == 0) begin
            t_we[k]   = 1'b0;
            t_addr[k] = 32'h100;
          end
        end
      end
      t_req   = pend;
      t_rdata = $urandom;

      @(negedge clk);
      eg = (rst || !t_ready) ? -1 : rr_pick(t_req, ptr);
      eg_oh = '0;
      if (eg >= 0) eg_oh[eg] = 1'b1;
      chk("gnt_l1", 64'(ifa.p_gnt_o), 64'(eg_oh));
      chk("gnt_l3", 64'(ifb.p_gnt_o), 64'(eg_oh));
      chk("mem_req", 64'({ifa.mem_req_o, ifb.mem_req_o}), 64'({2{eg >= 0}}));
      if (eg >= 0) begin
        e_addr = {t_addr[eg][31:2], 2'b00};
        chk("mem_addr", 64'(ifa.mem_addr_o), 64'(e_addr));
        chk("mem_fields", {ifb.mem_we_o, ifb.mem_be_o, ifb.mem_wdata_o},
            {t_we[eg], t_be[eg], t_wdata[eg]});
        ptr = eg;
        pend[eg] = 1'b0;
        q[0].push_back('{port: eg, we: t_we[eg], due: c + 1});
        q[1].push_back('{port: eg, we: t_we[eg], due: c + 3});
      end else begin
        chk("mem_idle", {ifa.mem_we_o, ifa.mem_be_o, ifa.mem_addr_o, ifa.mem_wdata_o}, 64'h0);
      end
    end
    // Drain in-flight responses with requests removed.
    for (int c = NCYC; c < NCYC + 6; c++) begin
      @(posedge clk); #1;
      cyc = c;
      t_req = '0;
      t_rdata = $urandom;
    end
    @(negedge clk);
    chk("drain_l1", 64'(q[0].size()), 64'h0);
    chk("drain_l3", 64'(q[1].size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Response monitor: pops the oldest expectation whenever a DUT presents rvalid.
  always @(negedge clk) begin
    logic [NP-1:0] rv;
    logic [31:0]   rd;
    logic [NP-1:0] oh;
    exp_t          e;
    for (int d = 0; d < 2; d++) begin
      rv = (d == 0) ? ifa.p_rvalid_o : ifb.p_rvalid_o;
      rd = (d == 0) ? ifa.p_rdata_o  : ifb.p_rdata_o;
      if (rv != '0) begin
        if (q[d].size() == 0) begin
          chk($sformatf("spurious_rvalid_d%0d", d), 64'(rv), 64'h0);
        end else begin
          e = q[d].pop_front();
          oh = '0;
          oh[e.port] = 1'b1;
          chk($sformatf("rvalid_port_d%0d", d), 64'(rv), 64'(oh));
          chk($sformatf("rvalid_time_d%0d", d), 64'(cyc), 64'(e.due));
          chk($sformatf("rdata_d%0d", d), 64'(rd), e.we ? 64'h0 : 64'(t_rdata));
        end
      end else begin
        chk($sformatf("rdata_idle_d%0d", d), 64'(rd), 64'h0);
        if (q[d].size() != 0 && q[d][0].due <= cyc) begin
          e = q[d].pop_front();
          oh = '0;
          oh[e.port] = 1'b1;
          chk($sformatf("missing_rvalid_d%0d", d), 64'(rv), 64'(oh));
        end
      end
    end
  end

endmodule
